// File: rtl/pipe_pkg.sv
// Shared definitions for datapath stage registers: state encoding and the
// occupancy values each state reports.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_t;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_FULL  = 2'd1;
  localparam logic [1:0] OCC_SKID  = 2'd2;

  function automatic logic [1:0] occ_of(input pipe_state_t st);
    case (st)
      FULL:    occ_of = OCC_FULL;
      SKID:    occ_of = OCC_SKID;
      default: occ_of = OCC_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter for performance debug; clear has priority over
// increment and the count sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage with a two-entry skid buffer, flush squash and
// a saturating stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Handshake: a beat moves on a port in any cycle where valid and ready are
  // both high at the rising edge; valid never depends on ready, and ready
  // here depends only on registered state.

  pipe_state_t       state_q, state_d;
  logic [DATA_W-1:0] m_q, m_d;
  logic [DATA_W-1:0] s_q, s_d;
  logic              fire_in;
  logic              fire_out;

  assign in_ready  = (state_q != SKID);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = m_q;
  assign occupancy = occ_of(state_q);

  assign fire_in  = in_valid && in_ready;
  assign fire_out = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (flush) begin
      // Squash drops held beats without touching the data registers.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (fire_in) begin
            state_d = FULL;
            m_d     = in_data;
          end
        end
        FULL: begin
          if (fire_in && fire_out) begin
            m_d = in_data;
          end else if (fire_in) begin
            state_d = SKID;
            s_d     = in_data;
          end else if (fire_out) begin
            state_d = EMPTY;
          end
        end
        SKID: begin
          if (fire_out) begin
            state_d = FULL;
            m_d     = s_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      m_q     <= RESET_VAL;
      s_q     <= RESET_VAL;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .clr (rst || cnt_clr),
    .inc (out_valid && !out_ready),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: reset, streaming, skid, flush, counter
// saturation and reset-over-flush, with hand-computed expectations.
module tb_pipe_stage_reg;

  localparam int                DATA_W    = 32;
  localparam int                CNT_W     = 3;
  localparam logic [DATA_W-1:0] RESET_VAL = 32'hDEAD_BEEF;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic              cnt_clr;
  logic [CNT_W-1:0]  stall_cnt;

  int n_tests;
  int n_fail;

  pipe_stage_reg #(
    .DATA_W    (DATA_W),
    .RESET_VAL (RESET_VAL),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .cnt_clr   (cnt_clr),
    .stall_cnt (stall_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;

    // Reset and single beat
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, RESET_VAL);
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_stall", 32'(stall_cnt), 32'd0);

    rst       = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h1234_5678;
    out_ready = 1'b1;
    #1;
    check("single_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("single_out_valid", 32'(out_valid), 32'd1);
    check("single_out_data", out_data, 32'h1234_5678);
    check("single_occ", 32'(occupancy), 32'd1);
    tick();
    check("single_drain_valid", 32'(out_valid), 32'd0);
    check("single_drain_occ", 32'(occupancy), 32'd0);

    // Streaming: 8 beats back to back, no bubbles
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i);
      tick();
      check($sformatf("stream_valid_%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("stream_data_%0d", i), out_data, 32'(i));
      check($sformatf("stream_occ_%0d", i), 32'(occupancy), 32'd1);
      check($sformatf("stream_in_ready_%0d", i), 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_end_occ", 32'(occupancy), 32'd0);
    check("stream_stall", 32'(stall_cnt), 32'd0);

    // Skid: A presented, out_ready drops, B parks in S, C held off
    in_valid = 1'b1;
    in_data  = 32'hA;
    tick();
    check("skid_a_data", out_data, 32'hA);
    out_ready = 1'b0;
    in_data   = 32'hB;
    tick();
    check("skid_occ2", 32'(occupancy), 32'd2);
    check("skid_in_ready0", 32'(in_ready), 32'd0);
    check("skid_hold_a", out_data, 32'hA);
    check("skid_stall1", 32'(stall_cnt), 32'd1);
    in_data = 32'hC;
    tick();
    check("skid_still_occ2", 32'(occupancy), 32'd2);
    check("skid_still_a", out_data, 32'hA);
    check("skid_stall2", 32'(stall_cnt), 32'd2);
    out_ready = 1'b1;
    tick();
    check("skid_b_data", out_data, 32'hB);
    check("skid_b_occ", 32'(occupancy), 32'd1);
    check("skid_b_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("skid_c_data", out_data, 32'hC);
    check("skid_c_valid", 32'(out_valid), 32'd1);
    tick();
    check("skid_drained", 32'(out_valid), 32'd0);
    check("skid_stall_kept", 32'(stall_cnt), 32'd2);

    // Flush while in SKID with D offered upstream
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h1;
    tick();
    in_data = 32'h2;
    tick();
    check("flush_pre_occ", 32'(occupancy), 32'd2);
    check("flush_pre_stall", 32'(stall_cnt), 32'd3);
    flush     = 1'b1;
    out_ready = 1'b1;
    in_data   = 32'hD;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_occ", 32'(occupancy), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_m_kept", out_data, 32'h1);
    check("flush_stall", 32'(stall_cnt), 32'd3);
    tick();
    check("flush_no_d_valid", 32'(out_valid), 32'd0);
    check("flush_no_d_data", out_data, 32'h1);

    // Counter saturation at 2^3-1
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("cnt_clr0", 32'(stall_cnt), 32'd0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h55;
    tick();
    in_valid = 1'b0;
    check("sat_start", 32'(stall_cnt), 32'd0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      check($sformatf("sat_%0d", i), 32'(stall_cnt), (i > 7) ? 32'd7 : 32'(i));
    end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("sat_clr", 32'(stall_cnt), 32'd0);
    check("sat_still_full", 32'(occupancy), 32'd1);

    // Reset over flush while FULL
    rst   = 1'b1;
    flush = 1'b1;
    tick();
    rst   = 1'b0;
    flush = 1'b0;
    check("rof_in_ready", 32'(in_ready), 32'd1);
    check("rof_out_valid", 32'(out_valid), 32'd0);
    check("rof_out_data", out_data, RESET_VAL);
    check("rof_occ", 32'(occupancy), 32'd0);
    check("rof_stall", 32'(stall_cnt), 32'd0);
    tick();
    check("rof_after_valid", 32'(out_valid), 32'd0);

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
